ps2_rx_fifo: RTL

- Next-generation PS/2 receiver for keyboard and mouse ports, replacing the single-keycode receiver.
- Filters and synchronises kclk/kdata, then samples frames on filtered kclk falling edges detected in the clk domain; no derived clocks.
- Checks start, parity and stop bits and applies an inactivity timeout.
- Buffers good bytes in a FIFO with a valid/ready read port and keeps a parametrised multi-byte keycode history for display logic.

---
 rtl/ps2_rx_fifo.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronise/filter kclk+kdata, frame decode on filtered kclk falls, byte FIFO + keycode history.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection (parity_err); otherwise parity is ignored.
module ps2_rx_fifo #(
   parameter int unsigned FILTER_LEN     = 76,
   parameter int unsigned TIMEOUT_CYCLES = 200000,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned HIST_BYTES     = 2
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              kclk,
   input  logic                              kdata,
   output logic [7:0]                        data,
   output logic                              data_valid,
   input  logic                              data_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic [8*HIST_BYTES-1:0]           keycode,
   output logic                              keycode_valid,
   output logic                              parity_err,
   output logic                              frame_err,
   output logic                              timeout_err,
   output logic                              overflow,
   input  logic                              clear_err
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- synchroniser and filter (index 0 = kclk, 1 = kdata)
   logic [1:0]          kclk_sync_q, kdata_sync_q;
   logic [1:0]          raw;
   logic [1:0]          filt_q, filt_d;
   logic [1:0][FCW-1:0] fcnt_q, fcnt_d;
   logic                fall_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         kclk_sync_q  <= '1;
         kdata_sync_q <= '1;
      end else begin
         kclk_sync_q  <= {kclk_sync_q[0], kclk};
         kdata_sync_q <= {kdata_sync_q[0], kdata};
      end
   end

   assign raw = {kdata_sync_q[1], kclk_sync_q[1]};

   // Output flips only after FILTER_LEN consecutive differing cycles; any agreement restarts the count.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         if (raw[i] != filt_q[i]) begin
            if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) filt_d[i] = raw[i];
            else                                    fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         filt_q <= '1;
         fcnt_q <= '0;
         fall_q <= 1'b0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
         fall_q <= filt_q[0] & ~filt_d[0];
      end
   end

   // ---------------- frame FSM
   state_t         state_q, state_d;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     bitidx_q, bitidx_d;
   logic [TCW-1:0] tcnt_q, tcnt_d;
   logic           push_q, push_d;
   logic [7:0]     byte_q, byte_d;
   logic           perr_q, perr_d;
   logic           ferr_q, ferr_d;
   logic           terr_q, terr_d;
   logic           kdata_f;
`ifdef PS2_PARITY_CHECK_EN
   logic           par_q, par_d;
`endif

   assign kdata_f = filt_q[1];

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitidx_d = bitidx_q;
      byte_d   = byte_q;
      push_d   = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      terr_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_d    = par_q;
`endif
      tcnt_d   = (state_q == S_IDLE || fall_q) ? '0 : tcnt_q + 1'b1;

      if (fall_q) begin
         unique case (state_q)
            S_IDLE: begin
               if (!kdata_f) begin
                  state_d  = S_DATA;
                  bitidx_d = '0;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            S_DATA: begin
               shift_d  = {kdata_f, shift_q[7:1]};
               bitidx_d = bitidx_q + 1'b1;
               if (bitidx_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = kdata_f;
`endif
               state_d = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               byte_d  = shift_q;
               if (!kdata_f) ferr_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
               else if (!(^{shift_q, par_q})) perr_d = 1'b1;
`endif
               else push_d = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE && tcnt_d == TCW'(TIMEOUT_CYCLES)) begin
         state_d = S_IDLE;
         terr_d  = 1'b1;
         tcnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bitidx_q <= '0;
         tcnt_q   <= '0;
         push_q   <= 1'b0;
         byte_q   <= '0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         terr_q   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitidx_q <= bitidx_d;
         tcnt_q   <= tcnt_d;
         push_q   <= push_d;
         byte_q   <= byte_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         terr_q   <= terr_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q    <= par_d;
`endif
      end
   end

   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign timeout_err = terr_q;

   // ---------------- keycode history
   logic [8*HIST_BYTES-1:0] keycode_q, keycode_d;
   logic                    kvalid_q;

   generate
      if (HIST_BYTES == 1) begin : g_hist1
         always_comb keycode_d = push_q ? byte_q : keycode_q;
      end else begin : g_histn
         always_comb keycode_d = push_q ? {keycode_q[8*HIST_BYTES-9:0], byte_q} : keycode_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         keycode_q <= '0;
         kvalid_q  <= 1'b0;
      end else begin
         keycode_q <= keycode_d;
         kvalid_q  <= push_q;
      end
   end

   assign keycode       = keycode_q;
   assign keycode_valid = kvalid_q;

   // ---------------- byte FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          ovf_q;
   logic          empty, full, do_pop, do_push, drop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(FIFO_DEPTH));
   assign do_pop  = !empty && data_ready;
   // When full, a simultaneous pop frees the slot being written, so the push still lands.
   assign do_push = push_q && (!full || do_pop);
   assign drop    = push_q && full && !do_pop;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= byte_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (drop)           ovf_q <= 1'b1;
         else if (clear_err) ovf_q <= 1'b0;
      end
   end

   assign data       = empty ? 8'h00 : mem_q[rd_q];
   assign data_valid = !empty;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;

endmodule
